aes_key_expander_seq: RTL and testbench

- Sequential, multi-mode AES key expander; parametrised successor of the combinational AES-128 key schedule.
- Supports AES-128/192/256 (FIPS-197), generating one 32-bit schedule word per cycle into internal word storage.
- Exposes a registered round-key read port for the datapath, with a start/ready/done handshake.
- Sits between key loading logic and the iterative AES round core; the round core reads round keys by index.

---
 rtl/aes_pkg.sv | 82 ++++++++
 rtl/aes_sub_word.sv | 13 +
 rtl/aes_key_expander_seq.sv | 188 ++++++++++++++++++
 tb/tb_aes_key_expander_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants: key-length codes, schedule geometry, Rcon and S-box.
package aes_pkg;

  localparam logic [1:0] KL_128 = 2'd0;
  localparam logic [1:0] KL_192 = 2'd1;
  localparam logic [1:0] KL_256 = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GEN  = 1'b1
  } exp_state_t;

  // Key length in 32-bit words; 0 flags an illegal code.
  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KL_128:  return 4'd4;
      KL_192:  return 4'd6;
      KL_256:  return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KL_128:  return 4'd10;
      KL_192:  return 4'd12;
      KL_256:  return 4'd14;
      default: return 4'd0;
    endcase
  endfunction

  // Total schedule length in words, 4*(Nr+1).
  function automatic logic [5:0] tot_of(input logic [1:0] kl);
    case (kl)
      KL_128:  return 6'd44;
      KL_192:  return 6'd52;
      KL_256:  return 6'd60;
      default: return 6'd0;
    endcase
  endfunction

  // Round constant; index 0 corresponds to Rcon[1].
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: byte-wise S-box substitution of one 32-bit schedule word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign word_o[8*gi +: 8] = sbox(word_i[8*gi +: 8]);
  end

endmodule

// File: rtl/aes_key_expander_seq.sv
// Sequential AES-128/192/256 key expander: one schedule word per cycle,
// registered round-key read port for the round core.
module aes_key_expander_seq
  import aes_pkg::*;
#(
  parameter int MAX_NK   = 8,
  parameter int RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          key_len,
  input  logic [255:0]        in_key,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic                key_valid,
  output logic                err,
  output logic [3:0]          nr,
  input  logic [RK_IDX_W-1:0] rk_idx,
  output logic [127:0]        rk_out
);

  localparam int TOT_MAX = 4 * (MAX_NK + 7);
  localparam int AW      = $clog2(TOT_MAX);

  logic [31:0] w_q [0:TOT_MAX-1];

  exp_state_t  state_q, state_d;
  logic [AW-1:0] i_q, i_d, tot_q, tot_d;
  logic [2:0]  m_q, m_d;            // i mod Nk
  logic [3:0]  rc_q, rc_d;          // Rcon index, bumped after each wrap
  logic [3:0]  nk_q, nk_d, nr_lat_q, nr_lat_d, nr_q, nr_d;
  logic        ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic        kv_q, kv_d, err_q, err_d;
  logic [127:0] rk_q;

  logic [3:0]  start_nk;
  logic        start_legal, load, wr_en;
  logic [31:0] prev_w, back_w, sub_in, sub_out, temp_w, new_w;
  logic [AW-1:0] rd_base;

  assign start_nk    = nk_of(key_len);
  assign start_legal = (key_len != 2'd3) && (int'(start_nk) <= MAX_NK);

  // Schedule recurrence for word i; one shared SubWord serves both cases.
  always_comb begin
    prev_w = w_q[i_q - AW'(1)];
    back_w = w_q[i_q - AW'(nk_q)];
    sub_in = (m_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    if (m_q == 3'd0)
      temp_w = sub_out ^ {rcon(rc_q), 24'h0};
    else if (nk_q == 4'd8 && m_q == 3'd4)
      temp_w = sub_out;
    else
      temp_w = prev_w;
    new_w = back_w ^ temp_w;
  end

  aes_sub_word u_sub_word (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  // Next-state and control for the IDLE/GEN sequencer.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    tot_d    = tot_q;
    m_d      = m_q;
    rc_d     = rc_q;
    nk_d     = nk_q;
    nr_lat_d = nr_lat_q;
    nr_d     = nr_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    kv_d     = kv_q;
    err_d    = 1'b0;
    load     = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (start_legal) begin
            load     = 1'b1;
            nk_d     = start_nk;
            nr_lat_d = nr_of(key_len);
            tot_d    = AW'(tot_of(key_len));
            i_d      = AW'(start_nk);
            m_d      = 3'd0;
            rc_d     = 4'd0;
            kv_d     = 1'b0;
            nr_d     = 4'd0;
            busy_d   = 1'b1;
            ready_d  = 1'b0;
            state_d  = ST_GEN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_GEN: begin
        wr_en = 1'b1;
        i_d   = i_q + AW'(1);
        m_d   = (m_q == 3'(nk_q - 4'd1)) ? 3'd0 : m_q + 3'd1;
        if (m_q == 3'd0) rc_d = rc_q + 4'd1;
        if (i_q == tot_q - AW'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          done_d  = 1'b1;
          kv_d    = 1'b1;
          nr_d    = nr_lat_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control register bank with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      i_q      <= '0;
      tot_q    <= '0;
      m_q      <= '0;
      rc_q     <= '0;
      nk_q     <= '0;
      nr_lat_q <= '0;
      nr_q     <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      kv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      tot_q    <= tot_d;
      m_q      <= m_d;
      rc_q     <= rc_d;
      nk_q     <= nk_d;
      nr_lat_q <= nr_lat_d;
      nr_q     <= nr_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      kv_q     <= kv_d;
      err_q    <= err_d;
    end
  end

  // Word storage: key words on accept, then one generated word per GEN cycle.
  // Not reset; key_valid guards every read.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int j = 0; j < MAX_NK; j++) begin
        if (4'(j) < start_nk) w_q[j] <= in_key[255 - 32*j -: 32];
      end
    end else if (wr_en) begin
      w_q[i_q] <= new_w;
    end
  end

  assign rd_base = AW'({rk_idx, 2'b00});

  // Registered round-key read; zero when schedule invalid or index past Nr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rk_q <= '0;
    end else if (kv_q && (int'(rk_idx) <= int'(nr_q))) begin
      rk_q <= {w_q[rd_base], w_q[rd_base + AW'(1)],
               w_q[rd_base + AW'(2)], w_q[rd_base + AW'(3)]};
    end else begin
      rk_q <= '0;
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign key_valid = kv_q;
  assign err       = err_q;
  assign nr        = nr_q;
  assign rk_out    = rk_q;

endmodule

// File: tb/tb_aes_key_expander_seq.sv
// Directed, table-driven bench for the sequential AES key expander.
module tb_aes_key_expander_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] in_key;
  logic         ready, busy, done, key_valid, err;
  logic [3:0]   nr;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  logic         start6;
  logic [1:0]   key_len6;
  logic [255:0] in_key6;
  logic         ready6, busy6, done6, key_valid6, err6;
  logic [3:0]   nr6;
  logic [3:0]   rk_idx6;
  logic [127:0] rk_out6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_key_expander_seq #(.MAX_NK(8), .RK_IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .in_key(in_key),
    .ready(ready), .busy(busy), .done(done), .key_valid(key_valid), .err(err),
    .nr(nr), .rk_idx(rk_idx), .rk_out(rk_out)
  );

  aes_key_expander_seq #(.MAX_NK(6), .RK_IDX_W(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .key_len(key_len6), .in_key(in_key6),
    .ready(ready6), .busy(busy6), .done(done6), .key_valid(key_valid6), .err(err6),
    .nr(nr6), .rk_idx(rk_idx6), .rk_out(rk_out6)
  );

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_cafef00d_01234567_89abcdef};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0123456789abcdef};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct {
    logic [1:0]   kl;
    logic [255:0] key;
    int           lat;
    logic [3:0]   nr;
    logic [3:0]   idx;
    logic [127:0] exp_rk;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an expansion and count cycles until done; optionally pulse start mid-GEN.
  task automatic expand(input logic [1:0] kl, input logic [255:0] key, input int poke, output int lat);
    key_len = kl; in_key = key; start = 1'b1; rk_idx = 4'd0;
    tick();
    start = 1'b0;
    chk("kv_drop_at_start", 128'(key_valid), 128'(0));
    chk("busy_at_start", 128'(busy), 128'(1));
    lat = 0;
    while (!done && lat < 200) begin
      if (poke != 0 && lat == poke) begin
        start = 1'b1; key_len = 2'd0; in_key = ~key;
      end
      tick();
      start = 1'b0;
      lat++;
      if (lat == 3) chk("read_while_busy", rk_out, 128'(0));
      if (poke != 0 && lat == poke + 1) chk("start_in_gen_no_err", 128'(err), 128'(0));
    end
  endtask

  initial begin
    int lat;

    vecs[0] = '{2'd0, K128, 40, 4'd10, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[1] = '{2'd0, K128, 40, 4'd10, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{2'd0, K128, 40, 4'd10, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3] = '{2'd0, K128, 40, 4'd10, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[4] = '{2'd1, K192, 46, 4'd12, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5};
    vecs[5] = '{2'd1, K192, 46, 4'd12, 4'd12, 128'he98ba06f448c773c8ecc720401002202};
    vecs[6] = '{2'd2, K256, 52, 4'd14, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4};
    vecs[7] = '{2'd2, K256, 52, 4'd14, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e};

    rst_n = 1'b0; start = 1'b0; key_len = 2'd0; in_key = '0; rk_idx = 4'd0;
    start6 = 1'b0; key_len6 = 2'd0; in_key6 = K256; rk_idx6 = 4'd0;
    repeat (3) tick();
    chk("rst_ready", 128'(ready), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_key_valid", 128'(key_valid), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_nr", 128'(nr), 128'(0));
    chk("rst_rk_out", rk_out, 128'(0));
    rst_n = 1'b1;
    tick();

    // Table-driven expansions and reads.
    for (int v = 0; v < 8; v++) begin
      expand(vecs[v].kl, vecs[v].key, 0, lat);
      chk($sformatf("v%0d_done_latency", v), 128'(lat), 128'(vecs[v].lat));
      chk($sformatf("v%0d_nr", v), 128'(nr), 128'(vecs[v].nr));
      chk($sformatf("v%0d_key_valid", v), 128'(key_valid), 128'(1));
      chk($sformatf("v%0d_ready", v), 128'(ready), 128'(1));
      rk_idx = vecs[v].idx;
      tick();
      chk($sformatf("v%0d_done_one_cycle", v), 128'(done), 128'(0));
      chk($sformatf("v%0d_rk%0d", v, vecs[v].idx), rk_out, vecs[v].exp_rk);
    end

    // AES-128: index beyond Nr reads zero.
    expand(2'd0, K128, 0, lat);
    chk("a128_latency", 128'(lat), 128'(40));
    rk_idx = 4'd11;
    tick();
    chk("rk_idx_past_nr", rk_out, 128'(0));

    // Illegal key_len: err pulse, nothing else changes.
    start = 1'b1; key_len = 2'd3; in_key = K256;
    tick();
    start = 1'b0;
    chk("illegal_err", 128'(err), 128'(1));
    chk("illegal_ready", 128'(ready), 128'(1));
    chk("illegal_busy", 128'(busy), 128'(0));
    chk("illegal_key_valid", 128'(key_valid), 128'(1));
    chk("illegal_nr", 128'(nr), 128'(10));
    rk_idx = 4'd10;
    tick();
    chk("illegal_err_pulse", 128'(err), 128'(0));
    chk("illegal_schedule_kept", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // AES-256 on a MAX_NK=6 build is rejected.
    start6 = 1'b1; key_len6 = 2'd2;
    tick();
    start6 = 1'b0;
    chk("nk6_err", 128'(err6), 128'(1));
    chk("nk6_ready", 128'(ready6), 128'(1));
    chk("nk6_busy", 128'(busy6), 128'(0));
    chk("nk6_key_valid", 128'(key_valid6), 128'(0));
    tick();
    chk("nk6_err_pulse", 128'(err6), 128'(0));

    // Start pulsed mid-GEN is ignored.
    expand(2'd2, K256, 10, lat);
    chk("poke_latency", 128'(lat), 128'(52));
    rk_idx = 4'd14;
    tick();
    chk("poke_rk14", rk_out, 128'hfe4890d1e6188d0b046df344706c631e);

    // Reset mid-GEN aborts to IDLE.
    start = 1'b1; key_len = 2'd0; in_key = K128; rk_idx = 4'd1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_ready", 128'(ready), 128'(1));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_key_valid", 128'(key_valid), 128'(0));
    chk("midrst_rk_out", rk_out, 128'(0));
    rst_n = 1'b1;
    tick();
    expand(2'd0, K128, 0, lat);
    chk("after_rst_latency", 128'(lat), 128'(40));
    rk_idx = 4'd1;
    tick();
    chk("after_rst_rk1", rk_out, 128'ha0fafe1788542cb123a339392a6c7605);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
